io_intr_timer: RTL and testbench

IO_INTR_TIMER -- requirements
Module: io_intr_timer

---
 rtl/io_intr_timer_pkg.sv | 40 ++++
 rtl/io_intr_timer_int_req_fsm.sv | 63 ++++++
 rtl/io_intr_timer.sv | 157 +++++++++++++++
 tb/tb_io_intr_timer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_intr_timer_pkg.sv
// Shared definitions for the IO interval timer: register indices, field
// positions, interrupt handshake states and small register packing helpers.
package io_intr_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_EXP = 0;
    localparam int STAT_OVR = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ACKED = 2'd2
    } int_state_e;

    function automatic logic [31:0] pack_ctrl(input logic en, input logic auto_rl, input logic ie);
        logic [31:0] v;
        v            = 32'd0;
        v[CTRL_EN]   = en;
        v[CTRL_AUTO] = auto_rl;
        v[CTRL_IE]   = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_status(input logic exp_f, input logic ovr_f);
        logic [31:0] v;
        v           = 32'd0;
        v[STAT_EXP] = exp_f;
        v[STAT_OVR] = ovr_f;
        return v;
    endfunction

endpackage

// File: rtl/io_intr_timer_int_req_fsm.sv
// Generic interrupt request/acknowledge handshake: raises interrupt while a
// request is pending and waits for the acknowledge to drop before re-arming.
module int_req_fsm
    import io_intr_timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic request,
    input  logic ack,
    input  logic cancel,
    output logic interrupt
);

    int_state_e state_r;
    logic       interrupt_r;

    // Handshake state and registered interrupt (high exactly in PEND)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            interrupt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (request) begin
                        state_r     <= ST_PEND;
                        interrupt_r <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        interrupt_r <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (ack) begin
                        state_r     <= ST_ACKED;
                        interrupt_r <= 1'b0;
                    end else if (cancel) begin
                        state_r     <= ST_IDLE;
                        interrupt_r <= 1'b0;
                    end else begin
                        state_r     <= ST_PEND;
                        interrupt_r <= 1'b1;
                    end
                end
                ST_ACKED: begin
                    interrupt_r <= 1'b0;
                    if (!ack) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACKED;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    interrupt_r <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = interrupt_r;

endmodule

// File: rtl/io_intr_timer.sv
// Memory-mapped down-counting interval timer with prescaler, auto-reload,
// sticky expiry/overrun status and an acknowledged interrupt request.
module io_intr_timer
    import io_intr_timer_pkg::*;
#(
    parameter logic [7:0]  BASE    = 8'hF0,
    parameter int unsigned PRE_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IO_CS_,
    input  logic        IO_RD_,
    input  logic        IO_WR_,
    input  logic [11:0] IO_Addr,
    input  logic [31:0] IO_Din,
    output logic [31:0] IO_Dout,
    output logic        IO_OE,
    output logic        interrupt,
    input  logic        int_ack
);

    localparam logic [15:0] PRE_LAST = 16'(PRE_DIV - 1);

    logic        sel_s;
    logic [1:0]  reg_idx_s;
    logic        wr_act_s;
    logic        wr_commit_s;
    logic        rd_act_s;
    logic        tick_s;
    logic        cpu_owns_s;
    logic        expire_s;
    logic [1:0]  stat_clr_s;
    logic [31:0] rd_data_s;
    logic        irq_request_s;
    logic        addr_unused_s;

    logic        wr_prev_r;
    logic [31:0] dout_r;
    logic        oe_r;
    logic [15:0] presc_r;
    logic        ctrl_en_r;
    logic        ctrl_auto_r;
    logic        ctrl_ie_r;
    logic [31:0] load_r;
    logic [31:0] count_r;
    logic        stat_exp_r;
    logic        stat_ovr_r;

    assign addr_unused_s = ^IO_Addr[1:0];

    // Bus decode, write edge detection, timer tick and read mux
    always_comb begin
        sel_s       = (IO_CS_ == 1'b0) && (IO_Addr[11:4] == BASE);
        reg_idx_s   = IO_Addr[3:2];
        wr_act_s    = sel_s && (IO_WR_ == 1'b0);
        wr_commit_s = wr_act_s && !wr_prev_r;
        // a simultaneous write strobe turns the read into a pure write
        rd_act_s    = sel_s && (IO_RD_ == 1'b0) && (IO_WR_ == 1'b1);
        tick_s      = ctrl_en_r && (presc_r == PRE_LAST);
        cpu_owns_s  = wr_commit_s && ((reg_idx_s == REG_CTRL) || (reg_idx_s == REG_COUNT));
        expire_s    = tick_s && !cpu_owns_s && (count_r == 32'd1);
        if (wr_commit_s && (reg_idx_s == REG_STATUS)) begin
            stat_clr_s = IO_Din[1:0];
        end else begin
            stat_clr_s = 2'b00;
        end
        case (reg_idx_s)
            REG_CTRL:   rd_data_s = pack_ctrl(ctrl_en_r, ctrl_auto_r, ctrl_ie_r);
            REG_LOAD:   rd_data_s = load_r;
            REG_COUNT:  rd_data_s = count_r;
            REG_STATUS: rd_data_s = pack_status(stat_exp_r, stat_ovr_r);
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Bus-side registers: write edge history and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prev_r <= 1'b0;
            dout_r    <= 32'd0;
            oe_r      <= 1'b0;
        end else begin
            wr_prev_r <= wr_act_s;
            oe_r      <= rd_act_s;
            dout_r    <= rd_act_s ? rd_data_s : 32'd0;
        end
    end

    // Prescaler: idles at zero while disabled, so enabling always starts a full period
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= 16'd0;
        end else if (!ctrl_en_r || tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Timer registers; a committed CTRL or COUNT write suppresses that clock's countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en_r   <= 1'b0;
            ctrl_auto_r <= 1'b0;
            ctrl_ie_r   <= 1'b0;
            load_r      <= 32'd0;
            count_r     <= 32'd0;
            stat_exp_r  <= 1'b0;
            stat_ovr_r  <= 1'b0;
        end else begin
            stat_exp_r <= (stat_exp_r & ~stat_clr_s[STAT_EXP]) | expire_s;
            stat_ovr_r <= (stat_ovr_r & ~stat_clr_s[STAT_OVR]) | (expire_s & stat_exp_r);
            if (wr_commit_s && (reg_idx_s == REG_LOAD)) begin
                load_r <= IO_Din;
            end
            if (cpu_owns_s) begin
                if (reg_idx_s == REG_CTRL) begin
                    ctrl_en_r   <= IO_Din[CTRL_EN];
                    ctrl_auto_r <= IO_Din[CTRL_AUTO];
                    ctrl_ie_r   <= IO_Din[CTRL_IE];
                end else begin
                    count_r <= IO_Din;
                end
            end else if (ctrl_en_r && (count_r == 32'd0)) begin
                if (ctrl_auto_r) begin
                    count_r <= load_r;
                end else begin
                    ctrl_en_r <= 1'b0;
                end
            end else if (tick_s) begin
                if (count_r == 32'd1) begin
                    count_r <= ctrl_auto_r ? load_r : 32'd0;
                    if (!ctrl_auto_r) begin
                        ctrl_en_r <= 1'b0;
                    end
                end else begin
                    count_r <= count_r - 32'd1;
                end
            end
        end
    end

    assign irq_request_s = stat_exp_r & ctrl_ie_r;

    int_req_fsm u_int_req_fsm (
        .clk       (clk),
        .reset     (reset),
        .request   (irq_request_s),
        .ack       (int_ack),
        .cancel    (!irq_request_s),
        .interrupt (interrupt)
    );

    assign IO_Dout = dout_r;
    assign IO_OE   = oe_r;

endmodule

// File: tb/tb_io_intr_timer.sv
// Directed bench for io_intr_timer: a cycle-level reference model checked on
// every clock, plus hand-computed expectations for key scenarios.
module tb_io_intr_timer;

    localparam logic [7:0] BASE    = 8'hF0;
    localparam int         PRE_DIV = 4;

    localparam logic [11:0] A_CTRL   = 12'hF00;
    localparam logic [11:0] A_LOAD   = 12'hF04;
    localparam logic [11:0] A_COUNT  = 12'hF08;
    localparam logic [11:0] A_STATUS = 12'hF0C;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        IO_CS_  = 1'b1;
    logic        IO_RD_  = 1'b1;
    logic        IO_WR_  = 1'b1;
    logic [11:0] IO_Addr = 12'h000;
    logic [31:0] IO_Din  = 32'd0;
    logic [31:0] IO_Dout;
    logic        IO_OE;
    logic        interrupt;
    logic        int_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_en = 0, m_auto = 0, m_ie = 0, m_exp = 0, m_ovr = 0;
    bit          m_wr_prev = 0, m_oe = 0, m_int = 0;
    int          m_phase = 0;
    int          m_irq = 0;   // 0 idle, 1 pending, 2 acknowledged
    logic [31:0] m_load = 0, m_count = 0, m_dout = 0;

    logic [31:0] rd_d;
    logic        rd_oe;
    logic        wr_oe;

    always #5 clk = ~clk;

    io_intr_timer #(.BASE(BASE), .PRE_DIV(PRE_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .IO_CS_    (IO_CS_),
        .IO_RD_    (IO_RD_),
        .IO_WR_    (IO_WR_),
        .IO_Addr   (IO_Addr),
        .IO_Din    (IO_Din),
        .IO_Dout   (IO_Dout),
        .IO_OE     (IO_OE),
        .interrupt (interrupt),
        .int_ack   (int_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] idx);
        case (idx)
            2'd0:    return {29'd0, m_ie, m_auto, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {30'd0, m_ovr, m_exp};
        endcase
    endfunction

    task automatic model_step();
        bit sel, wr, neww, rd, owns, tick, expire, old_exp, old_en;
        logic [1:0] idx;
        if (reset) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ovr = 0;
            m_wr_prev = 0; m_oe = 0; m_int = 0; m_phase = 0; m_irq = 0;
            m_load = 0; m_count = 0; m_dout = 0;
            return;
        end
        sel  = !IO_CS_ && (IO_Addr[11:4] == BASE);
        idx  = IO_Addr[3:2];
        wr   = sel && !IO_WR_;
        neww = wr && !m_wr_prev;
        m_wr_prev = wr;
        rd   = sel && !IO_RD_ && IO_WR_;
        m_oe   = rd;
        m_dout = rd ? m_reg(idx) : 32'd0;
        case (m_irq)
            0: if (m_exp && m_ie) m_irq = 1;
            1: if (int_ack) m_irq = 2; else if (!(m_exp && m_ie)) m_irq = 0;
            default: if (!int_ack) m_irq = 0;
        endcase
        m_int   = (m_irq == 1);
        old_exp = m_exp;
        old_en  = m_en;
        tick    = m_en && (m_phase == PRE_DIV - 1);
        owns    = neww && (idx == 2'd0 || idx == 2'd2);
        expire  = 0;
        if (!owns && m_en) begin
            if (m_count == 0) begin
                if (m_auto) m_count = m_load; else m_en = 0;
            end else if (tick) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    expire = 1;
                    if (m_auto) m_count = m_load; else m_en = 0;
                end
            end
        end
        m_phase = old_en ? (m_phase + 1) % PRE_DIV : 0;
        if (neww) begin
            case (idx)
                2'd0: begin m_en = IO_Din[0]; m_auto = IO_Din[1]; m_ie = IO_Din[2]; end
                2'd1: m_load = IO_Din;
                2'd2: m_count = IO_Din;
                default: begin
                    if (IO_Din[0]) m_exp = 0;
                    if (IO_Din[1]) m_ovr = 0;
                end
            endcase
        end
        if (expire) begin
            if (old_exp) m_ovr = 1;
            m_exp = 1;
        end
    endtask

    // per-cycle comparison against the model
    always begin
        @(posedge clk);
        model_step();
        #1;
        check("cyc_dout", IO_Dout, m_dout);
        check("cyc_oe", {31'd0, IO_OE}, {31'd0, m_oe});
        check("cyc_irq", {31'd0, interrupt}, {31'd0, m_int});
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input bit both);
        @(negedge clk);
        IO_CS_ = 1'b0; IO_Addr = a; IO_Din = d; IO_WR_ = 1'b0; IO_RD_ = both ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 wr_oe = IO_OE;
        @(negedge clk);
        IO_WR_ = 1'b1; IO_RD_ = 1'b1; IO_CS_ = 1'b1;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic oe);
        @(negedge clk);
        IO_CS_ = 1'b0; IO_Addr = a; IO_RD_ = 1'b0;
        @(posedge clk);
        #1 d = IO_Dout; oe = IO_OE;
        @(negedge clk);
        IO_RD_ = 1'b1; IO_CS_ = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dout", IO_Dout, 32'd0);
        check("rst_oe", {31'd0, IO_OE}, 32'd0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);
        reset = 1'b0;

        // periodic auto-reload timer: LOAD=5, PRE_DIV=4 -> expiry 20 clocks after enable
        bus_write(A_LOAD, 32'd5, 0);
        bus_write(A_CTRL, 32'h7, 0);
        repeat (20) @(posedge clk);
        #1;
        check("m_exp_at_20", {31'd0, m_exp}, 32'd1);
        check("m_count_reload", m_count, 32'd5);
        check("irq_before", {31'd0, interrupt}, 32'd0);
        @(posedge clk);
        #1 check("irq_after_exp", {31'd0, interrupt}, 32'd1);
        bus_read(A_STATUS, rd_d, rd_oe);
        check("status_exp", rd_d, 32'h1);
        check("status_oe", {31'd0, rd_oe}, 32'd1);

        // acknowledge for 3 clocks, then re-request because EXP is still set
        @(negedge clk) int_ack = 1'b1;
        @(posedge clk);
        #1 check("irq_ack_drop", {31'd0, interrupt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) int_ack = 1'b0;
        @(posedge clk);
        #1 check("irq_acked_idle", {31'd0, interrupt}, 32'd0);
        @(posedge clk);
        #1 check("irq_rerequest", {31'd0, interrupt}, 32'd1);

        // second expiry without clearing EXP -> overrun
        repeat (30) @(posedge clk);
        bus_read(A_STATUS, rd_d, rd_oe);
        check("status_ovr", rd_d, 32'h3);
        bus_write(A_CTRL, 32'h4, 0);
        bus_write(A_STATUS, 32'h1, 0);
        bus_read(A_STATUS, rd_d, rd_oe);
        check("status_w1c", rd_d, 32'h2);
        check("irq_cancel", {31'd0, interrupt}, 32'd0);

        // held write strobe lands on a decrement clock and commits only once
        bus_write(A_COUNT, 32'd50, 0);
        bus_write(A_CTRL, 32'h3, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        IO_CS_ = 1'b0; IO_Addr = A_COUNT; IO_Din = 32'd9; IO_WR_ = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        IO_WR_ = 1'b1; IO_CS_ = 1'b1;
        bus_read(A_COUNT, rd_d, rd_oe);
        check("held_write_once", rd_d, 32'd7);

        // address decode
        bus_read(12'hE08, rd_d, rd_oe);
        check("bad_base_oe", {31'd0, rd_oe}, 32'd0);
        check("bad_base_dout", rd_d, 32'd0);
        bus_read(A_COUNT, rd_d, rd_oe);
        check("good_base_oe", {31'd0, rd_oe}, 32'd1);

        // plain register writes and simultaneous read+write
        bus_write(A_CTRL, 32'h0, 0);
        bus_write(A_COUNT, 32'h1234_5678, 0);
        bus_read(A_COUNT, rd_d, rd_oe);
        check("count_rw", rd_d, 32'h1234_5678);
        bus_write(A_LOAD, 32'hAA, 1);
        check("rdwr_oe", {31'd0, wr_oe}, 32'd0);
        bus_read(A_LOAD, rd_d, rd_oe);
        check("rdwr_load", rd_d, 32'hAA);
        bus_read(12'hF03, rd_d, rd_oe);
        check("ctrl_zero", rd_d, 32'h0);

        // reset mid-write while interrupt is asserted
        bus_write(A_STATUS, 32'h3, 0);
        bus_write(A_LOAD, 32'd2, 0);
        bus_write(A_COUNT, 32'd2, 0);
        bus_write(A_CTRL, 32'h7, 0);
        for (int i = 0; i < 40 && interrupt !== 1'b1; i++) @(posedge clk);
        #1 check("irq_before_reset", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        IO_CS_ = 1'b0; IO_Addr = A_LOAD; IO_Din = 32'h55; IO_WR_ = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_dout", IO_Dout, 32'd0);
        check("rst_mid_oe", {31'd0, IO_OE}, 32'd0);
        check("rst_mid_irq", {31'd0, interrupt}, 32'd0);
        @(negedge clk);
        reset = 1'b0; IO_WR_ = 1'b1; IO_CS_ = 1'b1;
        bus_read(A_LOAD, rd_d, rd_oe);
        check("rst_load", rd_d, 32'd0);
        bus_read(A_CTRL, rd_d, rd_oe);
        check("rst_ctrl", rd_d, 32'd0);
        bus_read(A_STATUS, rd_d, rd_oe);
        check("rst_status", rd_d, 32'd0);

        // strobe held across reset commits once afterwards
        @(negedge clk);
        IO_CS_ = 1'b0; IO_Addr = A_COUNT; IO_Din = 32'h77; IO_WR_ = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        IO_WR_ = 1'b1; IO_CS_ = 1'b1;
        bus_read(A_COUNT, rd_d, rd_oe);
        check("post_rst_commit", rd_d, 32'h77);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
